// File: rtl/pipe_hazard_seq_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states, PC source codes,
// per-stage bit indices and the stall/flush masks built from them.
package pipe_hazard_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_TRAP_FL  = 2'd3
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_TRAP = 2'b10;

  // Bit positions of the stage registers inside stall/flush vectors.
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_WB    = 4;
  localparam int NUM_STG   = 5;

  typedef logic [NUM_STG-1:0] stg_vec_t;

  // Contiguous mask covering stages lo..hi inclusive.
  function automatic stg_vec_t stg_span(input int lo, input int hi);
    return stg_vec_t'((32'd1 << (hi + 1)) - (32'd1 << lo));
  endfunction

  localparam stg_vec_t STALL_MEM   = stg_span(STG_PC, STG_EXMEM);
  localparam stg_vec_t FLUSH_MEM   = stg_span(STG_WB, STG_WB);
  localparam stg_vec_t FLUSH_TRAP  = stg_span(STG_PC, STG_EXMEM);
  localparam stg_vec_t FLUSH_DRAIN = stg_span(STG_PC, STG_IFID);
  localparam stg_vec_t STALL_MD    = stg_span(STG_PC, STG_IDEX);
  localparam stg_vec_t FLUSH_MD    = stg_span(STG_EXMEM, STG_EXMEM);
  localparam stg_vec_t FLUSH_BR    = stg_span(STG_IFID, STG_IDEX);
  localparam stg_vec_t STALL_LU    = stg_span(STG_PC, STG_IFID);
  localparam stg_vec_t FLUSH_LU    = stg_span(STG_IDEX, STG_IDEX);

endpackage

// File: rtl/pipe_hazard_seq_stall_cnt.sv
// Loadable saturating down-counter shared by the mul/div wait and the trap drain sequence.
module stall_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         last
);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  // Final decrement step: the next cycle sees zero.
  assign last = (cnt <= W'(1));

endmodule

// File: rtl/pipe_hazard_seq.sv
// Stall/flush sequencer for the 5-stage core: arbitrates memory wait, trap entry, mul/div,
// taken branches and load-use hazards, and drives per-stage stall/flush plus PC source.
module pipe_hazard_seq
  import pipe_hazard_seq_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int TRAP_DRAIN = 2,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_use_i,
  input  logic       muldiv_start_i,
  input  logic       mem_req_i,
  input  logic       mem_ack_i,
  input  logic       br_taken_i,
  input  logic       trap_i,
  output logic [4:0] stall_o,
  output logic [4:0] flush_o,
  output logic [1:0] pc_sel_o,
  output logic       trap_ack_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] MD_LOAD   = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] TRAP_LOAD = CNT_W'(TRAP_DRAIN - 1);

  state_e             state, state_nxt;
  logic               trap_seen;
  logic               cnt_load, cnt_dec;
  logic [CNT_W-1:0]   cnt_load_val;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero, cnt_last;
  logic               mem_wait, trap_take;

  assign mem_wait  = mem_req_i & ~mem_ack_i;
  // A trap already acknowledged stays masked until trap_i drops, so one request yields one ack.
  assign trap_take = trap_i & ~trap_seen;

  stall_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      trap_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (trap_ack_o) begin
        trap_seen <= 1'b1;
      end else if (!trap_i) begin
        trap_seen <= 1'b0;
      end
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (mem_wait) begin
      state_nxt = ST_MEM_WAIT;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (trap_take) begin
            cnt_load     = 1'b1;
            cnt_load_val = TRAP_LOAD;
            state_nxt    = ST_TRAP_FL;
          end else if (muldiv_start_i && (MULDIV_LAT > 1)) begin
            cnt_load     = 1'b1;
            cnt_load_val = MD_LOAD;
            state_nxt    = ST_MD_WAIT;
          end
        end
        ST_MD_WAIT: begin
          // A trap aborts the in-flight mul/div and reuses the counter for the drain.
          if (trap_take) begin
            cnt_load     = 1'b1;
            cnt_load_val = TRAP_LOAD;
            state_nxt    = ST_TRAP_FL;
          end else begin
            cnt_dec = 1'b1;
            if (cnt_last) state_nxt = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          state_nxt = ST_RUN;
        end
        ST_TRAP_FL: begin
          if (cnt_zero) state_nxt = ST_RUN;
          else          cnt_dec   = 1'b1;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_o    = '0;
    flush_o    = '0;
    pc_sel_o   = PC_SEL_SEQ;
    trap_ack_o = 1'b0;
    busy_o     = 1'b0;
    if (!rst) begin
      busy_o = (state != ST_RUN);
      if (mem_wait) begin
        stall_o = STALL_MEM;
        flush_o = FLUSH_MEM;
      end else begin
        unique case (state)
          ST_RUN: begin
            if (trap_take) begin
              flush_o    = FLUSH_TRAP;
              pc_sel_o   = PC_SEL_TRAP;
              trap_ack_o = 1'b1;
            end else if (muldiv_start_i) begin
              stall_o = '0;
            end else if (br_taken_i) begin
              flush_o  = FLUSH_BR;
              pc_sel_o = PC_SEL_BR;
            end else if (ld_use_i) begin
              stall_o = STALL_LU;
              flush_o = FLUSH_LU;
            end
          end
          ST_MD_WAIT: begin
            if (trap_take) begin
              flush_o    = FLUSH_TRAP;
              pc_sel_o   = PC_SEL_TRAP;
              trap_ack_o = 1'b1;
            end else begin
              stall_o = STALL_MD;
              flush_o = FLUSH_MD;
            end
          end
          ST_TRAP_FL: flush_o = FLUSH_DRAIN;
          default:    stall_o = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Directed bench for pipe_hazard_seq: per-cycle stimulus tables with hand-computed
// {stall, flush, pc_sel, trap_ack, busy} expectations.
module tb_pipe_hazard_seq;
  import pipe_hazard_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_use_i, muldiv_start_i, mem_req_i, mem_ack_i, br_taken_i, trap_i;
  logic [4:0] stall_o, flush_o;
  logic [1:0] pc_sel_o;
  logic       trap_ack_o, busy_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_seq #(.MULDIV_LAT(4), .TRAP_DRAIN(2), .CNT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_use_i       (ld_use_i),
    .muldiv_start_i (muldiv_start_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .br_taken_i     (br_taken_i),
    .trap_i         (trap_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .pc_sel_o       (pc_sel_o),
    .trap_ack_o     (trap_ack_o),
    .busy_o         (busy_o)
  );

  // Observed vector: {stall[4:0], flush[4:0], pc_sel[1:0], trap_ack, busy}.
  function automatic logic [13:0] outs();
    return {stall_o, flush_o, pc_sel_o, trap_ack_o, busy_o};
  endfunction

  // Stimulus vector: {ld_use, muldiv_start, mem_req, mem_ack, br_taken, trap}.
  task automatic drive(input logic [5:0] v);
    {ld_use_i, muldiv_start_i, mem_req_i, mem_ack_i, br_taken_i, trap_i} = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(6'b111011);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_run++;
      if (outs() !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, outs(), 14'd0);
      end
      next_cycle();
    end
    rst = 1'b0;
    drive(6'b000000);
    @(negedge clk);
    n_run++;
    if (outs() !== 14'd0 || dut.state !== ST_RUN) begin
      n_fail++;
      $display("FAIL reset_release: outs %b state %0d want outs 0 state RUN", outs(), dut.state);
    end
    next_cycle();
  endtask

  task automatic test_ld_use_branch();
    logic [5:0]  stim [5] = '{6'b100000, 6'b000000, 6'b100010, 6'b000000, 6'b000010};
    logic [13:0] expv [5] = '{14'b00011_00100_00_0_0, 14'd0,
                              14'b00000_00110_01_0_0, 14'd0,
                              14'b00000_00110_01_0_0};
    for (int i = 0; i < 5; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_run++;
      if (outs() !== expv[i]) begin
        n_fail++;
        $display("FAIL ld_use_branch[%0d]: got %b want %b", i, outs(), expv[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_muldiv();
    logic [5:0]  stim [5] = '{6'b010000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    logic [13:0] expv [5] = '{14'd0,
                              14'b00111_01000_00_0_1, 14'b00111_01000_00_0_1,
                              14'b00111_01000_00_0_1, 14'd0};
    for (int i = 0; i < 5; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_run++;
      if (outs() !== expv[i]) begin
        n_fail++;
        $display("FAIL muldiv[%0d]: got %b want %b", i, outs(), expv[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_trap();
    logic [5:0]  stim [8] = '{6'b001000, 6'b001001, 6'b001001, 6'b001101,
                              6'b000001, 6'b000000, 6'b000000, 6'b000000};
    logic [13:0] expv [8] = '{14'b01111_10000_00_0_0, 14'b01111_10000_00_0_1,
                              14'b01111_10000_00_0_1, 14'b00000_00000_00_0_1,
                              14'b00000_01111_10_1_0, 14'b00000_00011_00_0_1,
                              14'b00000_00011_00_0_1, 14'd0};
    for (int i = 0; i < 8; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_run++;
      if (outs() !== expv[i]) begin
        n_fail++;
        $display("FAIL mem_trap[%0d]: got %b want %b", i, outs(), expv[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_md_trap();
    logic [5:0]  stim [6] = '{6'b010000, 6'b000000, 6'b000001,
                              6'b000000, 6'b000000, 6'b000000};
    logic [13:0] expv [6] = '{14'd0, 14'b00111_01000_00_0_1,
                              14'b00000_01111_10_1_1, 14'b00000_00011_00_0_1,
                              14'b00000_00011_00_0_1, 14'd0};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_run++;
      if (outs() !== expv[i]) begin
        n_fail++;
        $display("FAIL md_trap[%0d]: got %b want %b", i, outs(), expv[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_trap_hold();
    logic [5:0]  stim [9] = '{6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000000,
                              6'b000001, 6'b000000, 6'b000000, 6'b000000};
    logic [13:0] expv [9] = '{14'b00000_01111_10_1_0, 14'b00000_00011_00_0_1,
                              14'b00000_00011_00_0_1, 14'd0, 14'd0,
                              14'b00000_01111_10_1_0, 14'b00000_00011_00_0_1,
                              14'b00000_00011_00_0_1, 14'd0};
    for (int i = 0; i < 9; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_run++;
      if (outs() !== expv[i]) begin
        n_fail++;
        $display("FAIL trap_hold[%0d]: got %b want %b", i, outs(), expv[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  stim [8] = '{6'b100000, 6'b100000, 6'b001100, 6'b010010,
                              6'b100010, 6'b000000, 6'b000000, 6'b000000};
    logic [13:0] expv [8] = '{14'b00011_00100_00_0_0, 14'b00011_00100_00_0_0,
                              14'd0, 14'd0,
                              14'b00111_01000_00_0_1, 14'b00111_01000_00_0_1,
                              14'b00111_01000_00_0_1, 14'd0};
    for (int i = 0; i < 8; i++) begin
      drive(stim[i]);
      @(negedge clk);
      n_run++;
      if (outs() !== expv[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, outs(), expv[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_rst_in_md();
    drive(6'b010000);
    next_cycle();
    drive(6'b000000);
    @(negedge clk);
    n_run++;
    if (outs() !== 14'b00111_01000_00_0_1) begin
      n_fail++;
      $display("FAIL rst_md_pre: got %b want %b", outs(), 14'b00111_01000_00_0_1);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs() !== 14'd0) begin
      n_fail++;
      $display("FAIL rst_md_during: got %b want %b", outs(), 14'd0);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if (outs() !== 14'd0 || dut.state !== ST_RUN || dut.u_cnt.cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_md_after: outs %b state %0d cnt %0d want outs 0 state RUN cnt 0",
               outs(), dut.state, dut.u_cnt.cnt);
    end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(6'b000000);
    #1;
    test_reset();
    test_ld_use_branch();
    test_muldiv();
    test_mem_trap();
    test_md_trap();
    test_trap_hold();
    test_back_to_back();
    test_rst_in_md();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
